// File: rtl/lampfpu_sqrt_sched.sv
// lampfpu_sqrt_sched: two-requester round-robin scheduler for one
// bfloat16 sqrt / inverse-sqrt unit, one operation in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_i[1:0], op_i[1:0]         per-requester request and opcode
//                                 (0 = sqrt, 1 = inverse sqrt)
//   opA_i, opB_i                  bfloat16 operands of requester 0 / 1
//   gnt_o[1:0]                    one-cycle acceptance pulse (one-hot)
//   rsp_valid_o[1:0]              one-cycle result strobe to the owner
//   rsp_data_o, rsp_err_o         result and abort flag
//   busy_o                        high whenever not IDLE
//   u_doSqrt_o, u_doInvSqrt_o     start pulses to the unit
//   u_op_o                        operand to the unit (ISSUE..WAIT)
//   u_valid_i, u_res_i            unit completion strobe and result
//
// Optional feature: define LAMPFPU_SQRT_SCHED_TIMEOUT_EN to abort an
// operation after TIMEOUT_CYC WAIT cycles with a qNaN error response.

module lampfpu_sqrt_sched #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_i,
  input  logic [1:0]  op_i,
  input  logic [15:0] opA_i,
  input  logic [15:0] opB_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        u_doSqrt_o,
  output logic        u_doInvSqrt_o,
  output logic [15:0] u_op_o,
  input  logic        u_valid_i,
  input  logic [15:0] u_res_i
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_chk
    $error("TIMEOUT_CYC must be within 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        opc_q, opc_d;
  logic [15:0] opnd_q, opnd_d;
  logic [15:0] res_q, res_d;
  logic        win;
  logic [1:0]  own_oh;

`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // With both requesting, the one not served last wins.
  assign win    = (req_i == 2'b11) ? ~last_q : req_i[1];
  assign own_oh = {owner_q, ~owner_q};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    opc_d   = opc_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d = win;
          last_d  = win;
          opc_d   = op_i[win];
          opnd_d  = win ? opB_i : opA_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (u_valid_i) begin
          res_d   = u_res_i;
          state_d = S_RESP;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = 16'h7FC0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      opc_q   <= 1'b0;
      opnd_q  <= '0;
      res_q   <= '0;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      opc_q   <= opc_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Outputs are forced low for the whole reset cycle, even before the
  // state register has returned to IDLE.
  always_comb begin
    gnt_o         = '0;
    rsp_valid_o   = '0;
    rsp_data_o    = '0;
    rsp_err_o     = 1'b0;
    busy_o        = 1'b0;
    u_doSqrt_o    = 1'b0;
    u_doInvSqrt_o = 1'b0;
    u_op_o        = '0;
    if (!rst) begin
      busy_o = (state_q != S_IDLE);
      unique case (state_q)
        S_IDLE: ;
        S_ISSUE: begin
          gnt_o         = own_oh;
          u_doSqrt_o    = ~opc_q;
          u_doInvSqrt_o = opc_q;
          u_op_o        = opnd_q;
        end
        S_WAIT: begin
          u_op_o = opnd_q;
        end
        S_RESP: begin
          rsp_valid_o = own_oh;
          rsp_data_o  = res_q;
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
          rsp_err_o   = err_q;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lampfpu_sqrt_sched.sv
// tb_lampfpu_sqrt_sched: vector table, directed corner sequences and
// random traffic against a transaction-level arbitration model.

module tb_lampfpu_sqrt_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req_i;
  logic [1:0]  op_i;
  logic [15:0] opA_i;
  logic [15:0] opB_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        u_doSqrt_o;
  logic        u_doInvSqrt_o;
  logic [15:0] u_op_o;
  logic        u_valid_i;
  logic [15:0] u_res_i;

  int checks = 0;
  int failures = 0;

  lampfpu_sqrt_sched #(.TIMEOUT_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i         (req_i),
    .op_i          (op_i),
    .opA_i         (opA_i),
    .opB_i         (opB_i),
    .gnt_o         (gnt_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_err_o     (rsp_err_o),
    .busy_o        (busy_o),
    .u_doSqrt_o    (u_doSqrt_o),
    .u_doInvSqrt_o (u_doInvSqrt_o),
    .u_op_o        (u_op_o),
    .u_valid_i     (u_valid_i),
    .u_res_i       (u_res_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    bit          rst_first;
    logic [1:0]  req;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    int          lat;
    logic [15:0] res;
    logic [1:0]  gnt;
    logic        inv;
    logic [15:0] uop;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_a"}, {gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o}, '0);
    chk({nm, "_b"}, {busy_o, u_doSqrt_o, u_doInvSqrt_o, u_op_o}, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_i = '0;
    u_valid_i = 1'b0;
    @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
  endtask

  // Called with the request already driven at an IDLE negedge.
  task automatic serve(input logic [1:0] eg, input logic inv,
                       input logic [15:0] uop, input int lat,
                       input logic [15:0] res, input bit drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt_o == 2'b00 && n < 20);
    chk("gnt", gnt_o, eg);
    chk("gnt_lat", n, 1);
    chk("start", {u_doSqrt_o, u_doInvSqrt_o}, {~inv, inv});
    chk("uop_issue", u_op_o, uop);
    if (drop) begin
      req_i = req_i & ~eg;
      if (eg[0]) opA_i = 16'($urandom);
      else opB_i = 16'($urandom);
    end
    u_valid_i = 1'b1;
    u_res_i = 16'($urandom);
    @(negedge clk);
    u_valid_i = 1'b0;
    chk("wait_st", {busy_o, gnt_o, rsp_valid_o}, 5'b10000);
    chk("uop_hold", u_op_o, uop);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("wait_hold", {busy_o, rsp_valid_o, u_op_o}, {1'b1, 2'b00, uop});
    end
    u_res_i = res;
    u_valid_i = 1'b1;
    @(negedge clk);
    u_valid_i = 1'($urandom_range(0, 1));
    u_res_i = 16'($urandom);
    chk("rsp_valid", rsp_valid_o, eg);
    chk("rsp_data", rsp_data_o, res);
    chk("rsp_err", rsp_err_o, 1'b0);
    @(negedge clk);
    u_valid_i = 1'b0;
    chk("idle_after", {busy_o, rsp_valid_o}, 3'b000);
  endtask

  bit          pend[2];
  bit          opm[2];
  logic [15:0] valm[2];
  bit          last;
  int          w;
  int          n;

  task automatic raise(input int r);
    pend[r] = 1'b1;
    opm[r] = 1'($urandom_range(0, 1));
    valm[r] = 16'($urandom);
    req_i[r] = 1'b1;
    op_i[r] = opm[r];
    if (r == 0) opA_i = valm[r];
    else opB_i = valm[r];
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_i = '0;
    op_i = '0;
    opA_i = '0;
    opB_i = '0;
    u_valid_i = 1'b0;
    u_res_i = '0;

    tbl[0] = '{0, 2'b01, 2'b00, 16'h4080, 16'h0000, 4, 16'h4000,
               2'b01, 0, 16'h4080};
    tbl[1] = '{1, 2'b11, 2'b10, 16'h3F80, 16'h4080, 2, 16'h3F80,
               2'b01, 0, 16'h3F80};
    tbl[2] = '{0, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 16'h3F00,
               2'b10, 1, 16'h4080};
    tbl[3] = '{0, 2'b10, 2'b10, 16'h0000, 16'h4100, 0, 16'hBEEF,
               2'b10, 1, 16'h4100};
    tbl[4] = '{0, 2'b11, 2'b01, 16'h1234, 16'h5678, 3, 16'h1111,
               2'b01, 1, 16'h1234};
    tbl[5] = '{0, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 16'h2222,
               2'b10, 0, 16'h5678};
    tbl[6] = '{0, 2'b01, 2'b00, 16'h7F80, 16'h0000, 6, 16'h7F80,
               2'b01, 0, 16'h7F80};

    repeat (2) @(negedge clk);
    chk_quiet("reset_init");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst_first) do_reset();
      if (tbl[i].req != 2'b00) begin
        req_i = req_i | tbl[i].req;
        op_i = tbl[i].op;
        opA_i = tbl[i].a;
        opB_i = tbl[i].b;
      end
      serve(tbl[i].gnt, tbl[i].inv, tbl[i].uop, tbl[i].lat,
            tbl[i].res, 1'b1);
    end

    // Completion strobes while idle are ignored.
    for (int i = 0; i < 3; i++) begin
      u_valid_i = 1'b1;
      u_res_i = 16'hDEAD;
      @(negedge clk);
      chk("spurious", {busy_o, rsp_valid_o}, 3'b000);
    end
    u_valid_i = 1'b0;

    // Fairness under continuous requests.
    do_reset();
    req_i = 2'b11;
    op_i = 2'b00;
    opA_i = 16'h1111;
    opB_i = 16'h2222;
    serve(2'b01, 0, 16'h1111, 1, 16'hA001, 1'b0);
    serve(2'b10, 0, 16'h2222, 0, 16'hA002, 1'b0);
    serve(2'b01, 0, 16'h1111, 2, 16'hA003, 1'b0);
    serve(2'b10, 0, 16'h2222, 1, 16'hA004, 1'b0);
    req_i = 2'b00;

    // Reset two cycles into WAIT, then a late completion.
    req_i = 2'b01;
    op_i = 2'b00;
    opA_i = 16'h4444;
    @(negedge clk);
    chk("mw_gnt", gnt_o, 2'b01);
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("mw_rst");
    rst = 1'b0;
    u_valid_i = 1'b1;
    u_res_i = 16'hDEAD;
    @(negedge clk);
    chk("mw_late", {busy_o, rsp_valid_o}, 3'b000);
    u_valid_i = 1'b0;
    @(negedge clk);
    chk("mw_idle", {busy_o, rsp_valid_o}, 3'b000);
    req_i = 2'b11;
    op_i = 2'b00;
    opA_i = 16'h0101;
    opB_i = 16'h0202;
    serve(2'b01, 0, 16'h0101, 1, 16'h5555, 1'b1);
    serve(2'b10, 0, 16'h0202, 2, 16'h6666, 1'b1);

    // Random traffic against the arbitration model.
    do_reset();
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    last = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1) raise(r);
      if (!pend[0] && !pend[1]) raise(int'($urandom_range(0, 1)));
      if (pend[0] && pend[1]) w = last ? 0 : 1;
      else w = pend[1] ? 1 : 0;
      serve(w == 1 ? 2'b10 : 2'b01, opm[w], valm[w],
            int'($urandom_range(0, 4)), 16'($urandom), 1'b1);
      pend[w] = 1'b0;
      last = (w == 1);
    end

    // Unit never responds.
    do_reset();
    req_i = 2'b01;
    op_i = 2'b00;
    opA_i = 16'hABCD;
    @(negedge clk);
    chk("to_gnt", gnt_o, 2'b01);
    req_i = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid_o == 2'b00 && n < 30);
`ifdef LAMPFPU_SQRT_SCHED_TIMEOUT_EN
    chk("to_cycles", n, 9);
    chk("to_valid", rsp_valid_o, 2'b01);
    chk("to_err", rsp_err_o, 1'b1);
    chk("to_data", rsp_data_o, 16'h7FC0);
    @(negedge clk);
    chk("to_idle", busy_o, 1'b0);
`else
    chk("to_none", n, 30);
    chk("to_busy", {busy_o, rsp_valid_o}, 3'b100);
    do_reset();
`endif
    req_i = 2'b10;
    op_i = 2'b10;
    opB_i = 16'h3C00;
    serve(2'b10, 1, 16'h3C00, 2, 16'h3800, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
